clm_rand_feeder: RTL and testbench
==================================

// Module: clm_rand_feeder
// PURPOSE
//   Upstream stage of the masked multiplier. Captures an operand pair on a drdy handshake.
//   Generates N_WORDS fresh masking words from an internal LFSR.
//   Then issues operands plus random_vect to the multiplier with a one-cycle drdy_o pulse.
//   Guarantees every multiplication gets a never-reused random vector.
// PARAMETERS
//   D        2   masking order; N_WORDS = 2*(8+D) random words per multiplication
//   R_W      3   width of one red_poly_t random word (D+1)
//   STATE_W  24  width of one state_t operand (8*(D+1))
//   LFSR_W   32  LFSR width; Galois, tap mask 32'h8020_0003
// PORTS
//   clk          in   1               clock, rising edge
//   rst          in   1               reset, asynchronous, active-low
//   seed_load    in   1               load seed into LFSR (honoured in IDLE only)
//   seed         in   LFSR_W          LFSR seed; all-zero seed is replaced by 1
//   drdy_i       in   1               operand pair valid, single-cycle pulse
//   p1_i, p2_i   in   STATE_W         operands, sampled when drdy_i accepted
//   drdy_o       out  1               one-cycle pulse to multiplier drdy_i
//   p1_o, p2_o   out  STATE_W         registered operands to multiplier
//   random_vect  out  N_WORDS*R_W     word k at bits [k*R_W +: R_W], k=0..N_WORDS-1
//   busy         out  1               high in FILL and ISSUE
//   overrun      out  1               sticky: a drdy_i arrived while busy; cleared by reset only
// BEHAVIOUR
//   Reset (rst=0, async):
//     state=IDLE, LFSR=1, fill index=0; all outputs 0.
//   IDLE:
//     - drdy_i=1: capture p1_i/p2_i into p1_o/p2_o, index=0, go to FILL.
//     - seed_load=1: LFSR <= (seed==0) ? 1 : seed.
//     - Both in the same cycle: seed loads first, and FILL uses the new seed.
//   FILL (exactly N_WORDS cycles):
//     - Each cycle the LFSR advances R_W single-bit Galois steps (combinational unroll).
//     - Word[index] <= low R_W bits of the new LFSR state; index++.
//     - When index==N_WORDS-1, go to ISSUE.
//   ISSUE (1 cycle):
//     - drdy_o=1; go to IDLE.
//   Latency: drdy_i accepted in cycle t -> drdy_o high in cycle t+N_WORDS+1 (t+21 for D=2).
//   Output stability: p1_o/p2_o/random_vect stay stable from ISSUE until the next accepted
//     drdy_i. The multiplier samples them with drdy_o.
//   Handshake rules:
//     - drdy_i while busy: dropped, no capture, overrun<=1; the current operation is unaffected.
//     - seed_load outside IDLE: ignored.
//   Back-to-back: drdy_i in the cycle after ISSUE (state back in IDLE) is accepted.
//   LFSR: never reaches the all-zero state. The state persists across operations, so
//     consecutive random vectors never repeat within the LFSR period.
//   Reset mid-FILL/ISSUE: immediate return to IDLE, drdy_o=0, no pulse issued, vector cleared.
// TESTING
//   1. Reset, seed=32'h0000_0001, drdy_i with p1_i=24'hA5A5A5, p2_i=24'h3C3C3C
//      -> drdy_o exactly at t+21; p1_o/p2_o equal inputs; random_vect matches the
//      reference LFSR model word-by-word.
//   2. Two back-to-back requests (second at the cycle after ISSUE)
//      -> both issued; the two random_vect values differ; LFSR continues without re-seeding.
//   3. drdy_i pulses at t+5 and t+20 during FILL
//      -> ignored, operands unchanged, overrun=1 and stays 1 after the next operation.
//   4. seed_load with seed=0 in IDLE -> LFSR=1 (same vector as test 1).
//      seed_load during FILL -> no effect on the vector.
//   5. rst low at t+10 of FILL -> all outputs 0 asynchronously, no drdy_o pulse.
//      A new request after release completes normally.
//   6. seed_load and drdy_i in the same IDLE cycle with seed=32'hDEADBEEF
//      -> random_vect derived from 32'hDEADBEEF.

Source files
------------

// File: rtl/clm_rand_feeder.sv
// Operand/randomness feeder for the masked multiplier: captures an operand pair,
// fills a fresh masking vector from a persistent Galois LFSR, then issues both with a pulse.
module clm_rand_feeder #(
  parameter int D       = 2,
  parameter int R_W     = D + 1,
  parameter int STATE_W = 8 * (D + 1),
  parameter int LFSR_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           seed_load,
  input  logic [LFSR_W-1:0]              seed,
  input  logic                           drdy_i,
  input  logic [STATE_W-1:0]             p1_i,
  input  logic [STATE_W-1:0]             p2_i,
  output logic                           drdy_o,
  output logic [STATE_W-1:0]             p1_o,
  output logic [STATE_W-1:0]             p2_o,
  output logic [2*(8+D)*R_W-1:0]         random_vect,
  output logic                           busy,
  output logic                           overrun
);

  localparam int N_WORDS = 2 * (8 + D);
  localparam int VEC_W   = N_WORDS * R_W;
  localparam int IDX_W   = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(32'h8020_0003);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE} state_t;

  state_t               state_q, state_d;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d, lfsr_step;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [STATE_W-1:0]   p1_q, p1_d, p2_q, p2_d;
  logic [VEC_W-1:0]     vect_q, vect_d;
  logic                 ovr_q, ovr_d;

  // One FILL cycle advances the LFSR by a full word's worth of single-bit steps.
  function automatic logic [LFSR_W-1:0] lfsr_adv(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] r;
    r = s;
    for (int i = 0; i < R_W; i++) begin
      r = r[0] ? ((r >> 1) ^ TAPS) : (r >> 1);
    end
    return r;
  endfunction

  assign lfsr_step = lfsr_adv(lfsr_q);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    vect_d  = vect_q;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE: begin
        // A seed loaded alongside a request is the state the fill starts from.
        if (seed_load) lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
        if (drdy_i) begin
          p1_d    = p1_i;
          p2_d    = p2_i;
          idx_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        lfsr_d = lfsr_step;
        vect_d[int'(idx_q)*R_W +: R_W] = lfsr_step[R_W-1:0];
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = S_ISSUE;
        if (drdy_i) ovr_d = 1'b1;
      end
      S_ISSUE: begin
        state_d = S_IDLE;
        if (drdy_i) ovr_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_W'(1);
      idx_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      vect_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      vect_q  <= vect_d;
      ovr_q   <= ovr_d;
    end
  end

  assign drdy_o      = (state_q == S_ISSUE);
  assign busy        = (state_q != S_IDLE);
  assign p1_o        = p1_q;
  assign p2_o        = p2_q;
  assign random_vect = vect_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_clm_rand_feeder.sv
// Scoreboard bench for clm_rand_feeder: requests push expected operands, vector and
// issue cycle; a negedge monitor pops and compares on every drdy_o pulse.
module tb_clm_rand_feeder;

  localparam int STATE_W = 24;
  localparam int LFSR_W  = 32;
  localparam int VEC_W   = 60;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic                clk, rst_n, seed_load, drdy_i;
  logic [LFSR_W-1:0]   seed;
  logic [STATE_W-1:0]  p1_i, p2_i, p1_o, p2_o;
  logic [VEC_W-1:0]    random_vect;
  logic                drdy_o, busy, overrun;

  clm_rand_feeder dut (
    .clk(clk), .rst(rst_n), .seed_load(seed_load), .seed(seed),
    .drdy_i(drdy_i), .p1_i(p1_i), .p2_i(p2_i),
    .drdy_o(drdy_o), .p1_o(p1_o), .p2_o(p2_o), .random_vect(random_vect),
    .busy(busy), .overrun(overrun)
  );

  typedef struct {
    logic [STATE_W-1:0] p1;
    logic [STATE_W-1:0] p2;
    logic [VEC_W-1:0]   v;
    int                 cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] model;
  logic [VEC_W-1:0] v1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference generator: 20 words, each the low 3 bits after three right-shift Galois steps.
  task automatic ref_vect(inout logic [31:0] s, output logic [VEC_W-1:0] v);
    v = '0;
    for (int k = 0; k < 20; k++) begin
      for (int b = 0; b < 3; b++) begin
        if (s[0]) s = (s >> 1) ^ POLY;
        else      s = s >> 1;
      end
      v[k*3 +: 3] = s[2:0];
    end
  endtask

  always @(negedge clk) begin
    if (drdy_o) begin
      if (q.size() == 0) begin
        chk("unexpected_drdy_o", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("issue_cycle", 64'(cyc), 64'(e.cyc));
        chk("p1_o", 64'(p1_o), 64'(e.p1));
        chk("p2_o", 64'(p2_o), 64'(e.p2));
        chk("random_vect", 64'(random_vect), 64'(e.v));
      end
    end
  end

  task automatic do_req(input logic [23:0] a, input logic [23:0] b,
                        input logic ld, input logic [31:0] sd, output int exp_cyc);
    exp_t e;
    @(negedge clk);
    drdy_i = 1'b1; p1_i = a; p2_i = b; seed_load = ld; seed = sd;
    if (ld) model = (sd == 0) ? 32'd1 : sd;
    ref_vect(model, e.v);
    e.p1 = a; e.p2 = b; e.cyc = cyc + 21;
    exp_cyc = e.cyc;
    q.push_back(e);
    @(negedge clk);
    drdy_i = 1'b0; seed_load = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_issue(input int exp_cyc);
    wait_cyc(exp_cyc);
    #1;
    chk("pending_after_issue", 64'(q.size()), 64'd0);
  endtask

  task automatic pulse_drdy(input logic [23:0] a, input logic [23:0] b);
    drdy_i = 1'b1; p1_i = a; p2_i = b;
    @(negedge clk);
    drdy_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ec, c;
    rst_n = 1'b0; seed_load = 1'b0; seed = '0; drdy_i = 1'b0; p1_i = '0; p2_i = '0;
    model = 32'd1;
    #1;
    chk("rst_drdy_o", 64'(drdy_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_vect", 64'(random_vect), 64'd0);
    chk("rst_p1_o", 64'(p1_o), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Test 1: seed 1, basic operation
    do_req(24'hA5A5A5, 24'h3C3C3C, 1'b1, 32'h0000_0001, ec);
    wait_cyc(ec - 16);
    chk("t1_busy_fill", 64'(busy), 64'd1);
    wait_issue(ec);
    chk("t1_words_0_1", 64'(random_vect[5:0]), 64'o11);
    chk("t1_busy_issue", 64'(busy), 64'd1);
    v1 = random_vect;

    // Test 2: back-to-back, LFSR continues
    do_req(24'h123456, 24'h654321, 1'b0, 32'h0, ec);
    wait_issue(ec);
    checks++;
    if (random_vect === v1) begin
      errors++;
      $display("FAIL t2_vect_differs got %h expected not %h", random_vect, v1);
    end
    chk("t2_overrun", 64'(overrun), 64'd0);

    // Test 3: drops during FILL
    do_req(24'h0F0F0F, 24'hF0F0F0, 1'b0, 32'h0, ec);
    c = ec - 21;
    wait_cyc(c + 5);
    pulse_drdy(24'hFFFFFF, 24'h000001);
    wait_cyc(c + 20);
    pulse_drdy(24'hEEEEEE, 24'h000002);
    wait_issue(ec);
    chk("t3_overrun", 64'(overrun), 64'd1);

    // Test 4: zero seed in IDLE maps to 1; seed_load during FILL ignored
    do_req(24'hA5A5A5, 24'h3C3C3C, 1'b1, 32'h0, ec);
    wait_issue(ec);
    chk("t4_same_as_t1", 64'(random_vect), 64'(v1));
    chk("t4_overrun_sticky", 64'(overrun), 64'd1);
    do_req(24'h111111, 24'h222222, 1'b0, 32'h0, ec);
    wait_cyc(ec - 18);
    seed_load = 1'b1; seed = 32'hDEAD_BEEF;
    @(negedge clk);
    seed_load = 1'b0;
    wait_issue(ec);

    // Test 5: reset mid-FILL
    do_req(24'h333333, 24'h444444, 1'b0, 32'h0, ec);
    wait_cyc(ec - 11);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_drdy_o", 64'(drdy_o), 64'd0);
    chk("t5_vect", 64'(random_vect), 64'd0);
    chk("t5_p2_o", 64'(p2_o), 64'd0);
    chk("t5_overrun", 64'(overrun), 64'd0);
    q.delete();
    model = 32'd1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    do_req(24'hA5A5A5, 24'h3C3C3C, 1'b0, 32'h0, ec);
    wait_issue(ec);
    chk("t5_after_reset_vect", 64'(random_vect), 64'(v1));

    // Test 6: seed and request together
    do_req(24'hCAFE01, 24'hBEEF02, 1'b1, 32'hDEAD_BEEF, ec);
    wait_issue(ec);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
